// File: rtl/demultiplexer4_pkg.sv
// Shared constants and the port-select decode for the 1-to-4 stream demultiplexer.
package demultiplexer4_pkg;

    localparam int NUM_PORTS = 4;
    localparam int SEL_W     = 2;

    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [SEL_W-1:0] sel);
        port_onehot      = '0;
        port_onehot[sel] = 1'b1;
    endfunction

endpackage

// File: rtl/demux_fifo.sv
// Per-port FIFO: head is storage[rd_ptr] at all times, storage cleared on reset.
// Latency: a push is visible at the head one edge later. Full refuses push even when popped same cycle.
module demux_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/demultiplexer4.sv
// Buffered 1-to-4 demux: word goes to FIFO[in_sel], each port drained by its own valid/ready.
// Latency: 1 cycle in->out, no combinational in->out path. A full target FIFO stalls the whole input.
module demultiplexer4
    import demultiplexer4_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic             busy
);

    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] empty;
    logic [NUM_PORTS-1:0] push;
    logic [NUM_PORTS-1:0] pop;
    logic [WIDTH-1:0]     head [NUM_PORTS];

    // Ready looks only at the selected FIFO's registered fill state, never at out_ready
    assign in_ready  = ~full[in_sel];
    assign push      = (in_valid & in_ready) ? port_onehot(in_sel) : '0;
    assign pop       = out_ready & ~empty;
    assign out_valid = ~empty;
    assign busy      = |(~empty);

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
        demux_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clock     (clock),
            .reset_n   (reset_n),
            .push      (push[k]),
            .push_data (in_data),
            .pop       (pop[k]),
            .full      (full[k]),
            .empty     (empty[k]),
            .head      (head[k])
        );
    end

    assign out_data0 = head[0];
    assign out_data1 = head[1];
    assign out_data2 = head[2];
    assign out_data3 = head[3];

endmodule

// File: tb/tb_demultiplexer4.sv
// Directed bench for demultiplexer4 (WIDTH=32, DEPTH=2): routing, backpressure, isolation, wrap, reset.
module tb_demultiplexer4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_sel;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data0, out_data1, out_data2, out_data3;
    logic        busy;

    int checks = 0;
    int errors = 0;

    demultiplexer4 #(.WIDTH(32), .DEPTH(2)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic push_word(input logic [1:0] sel, input logic [31:0] d);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    logic [31:0] q[$];
    int          sent;
    int          got;
    logic        rdy;
    logic        exp_pop;
    logic        exp_push;
    logic [31:0] rout [4];

    initial begin
        // reset with a pending word on the input
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 2'd2;
        in_data   = 32'hDEAD_BEEF;
        out_ready = 4'b0000;
        #23;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_out_data2", out_data2, 32'h0);
        in_valid = 1'b0;
        reset_n  = 1'b1;
        tick();
        tick();
        chk("rel_out_valid", 32'(out_valid), 32'h0);

        // routing to each port, consumers always ready
        out_ready = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_sel   = 2'(k);
            in_data  = 32'hA0 + 32'(k);
            tick();
            rout[0] = out_data0; rout[1] = out_data1; rout[2] = out_data2; rout[3] = out_data3;
            chk($sformatf("route%0d_valid", k), 32'(out_valid), 32'(1) << k);
            chk($sformatf("route%0d_data", k), rout[k], 32'hA0 + 32'(k));
        end
        in_valid = 1'b0;
        tick();
        chk("route_drained", 32'(out_valid), 32'h0);
        chk("route_busy", 32'(busy), 32'h0);

        // backpressure on port 1
        out_ready = 4'b0000;
        push_word(2'd1, 32'h11);
        push_word(2'd1, 32'h22);
        in_valid = 1'b1;
        in_sel   = 2'd1;
        in_data  = 32'h33;
        #1;
        chk("bp_full_ready", 32'(in_ready), 32'h0);
        chk("bp_valid", 32'(out_valid), 32'h2);
        chk("bp_head", out_data1, 32'h11);
        out_ready = 4'b0010;
        tick();
        chk("bp_head2", out_data1, 32'h22);
        chk("bp_ready_after_pop", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        chk("bp_head3", out_data1, 32'h33);
        chk("bp_valid3", 32'(out_valid), 32'h2);
        tick();
        chk("bp_drained", 32'(out_valid), 32'h0);

        // full port 3 popped in the same cycle still refuses the push
        out_ready = 4'b0000;
        push_word(2'd3, 32'h31);
        push_word(2'd3, 32'h32);
        in_valid  = 1'b1;
        in_sel    = 2'd3;
        in_data   = 32'h33;
        out_ready = 4'b1000;
        #1;
        chk("fp_ready", 32'(in_ready), 32'h0);
        tick();
        chk("fp_head2", out_data3, 32'h32);
        chk("fp_ready_next", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        chk("fp_head3", out_data3, 32'h33);
        tick();
        chk("fp_drained", 32'(out_valid), 32'h0);

        // isolation and head-of-line blocking
        out_ready = 4'b0000;
        push_word(2'd0, 32'h01);
        push_word(2'd0, 32'h02);
        in_valid = 1'b1;
        in_sel   = 2'd2;
        in_data  = 32'h21;
        #1;
        chk("iso_p2_ready", 32'(in_ready), 32'h1);
        tick();
        chk("iso_valid", 32'(out_valid), 32'h5);
        in_sel    = 2'd0;
        in_data   = 32'h03;
        out_ready = 4'b0100;
        #1;
        chk("hol_ready", 32'(in_ready), 32'h0);
        tick();
        chk("hol_p2_drained", 32'(out_valid), 32'h1);
        chk("hol_p0_head", out_data0, 32'h01);
        out_ready = 4'b0001;
        tick();
        chk("hol_p0_head2", out_data0, 32'h02);
        tick();
        in_valid = 1'b0;
        chk("hol_p0_head3", out_data0, 32'h03);
        tick();
        chk("hol_drained", 32'(out_valid), 32'h0);
        chk("hol_stale_head", out_data0, 32'h02);

        // wrap: 10 words through port 1 with random consumer ready
        sent = 0;
        got  = 0;
        q.delete();
        for (int cyc = 0; cyc < 300 && got < 10; cyc++) begin
            rdy       = 1'($urandom_range(0, 1));
            out_ready = {2'b00, rdy, 1'b0};
            in_valid  = (sent < 10);
            in_sel    = 2'd1;
            in_data   = 32'h100 + 32'(sent);
            #1;
            chk("wrap_ready", 32'(in_ready), 32'(q.size() < 2));
            chk("wrap_valid", 32'(out_valid[1]), 32'(q.size() > 0));
            exp_pop  = (q.size() > 0) && rdy;
            exp_push = in_valid && (q.size() < 2);
            if (exp_pop) begin
                chk("wrap_data", out_data1, q[0]);
            end
            tick();
            if (exp_pop) begin
                void'(q.pop_front());
                got++;
            end
            if (exp_push) begin
                q.push_back(32'h100 + 32'(sent));
                sent++;
            end
        end
        in_valid = 1'b0;
        chk("wrap_count", 32'(got), 32'd10);

        // reset with two words buffered discards them immediately
        out_ready = 4'b0000;
        push_word(2'd1, 32'h55);
        push_word(2'd1, 32'h66);
        chk("mrst_pre_valid", 32'(out_valid), 32'h2);
        reset_n = 1'b0;
        #1;
        chk("mrst_valid", 32'(out_valid), 32'h0);
        chk("mrst_busy", 32'(busy), 32'h0);
        chk("mrst_in_ready", 32'(in_ready), 32'h1);
        chk("mrst_data1", out_data1, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("mrst_rel_valid", 32'(out_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demultiplexer4.md
# demultiplexer4

Buffered 1-to-4 stream demultiplexer for the rvsimple datapath: accepts one valid/ready stream tagged with a 2-bit port select and delivers each word to one of four independent valid/ready output streams. Each output port has its own small FIFO, so a slow consumer only stalls traffic addressed to it. It is the distribution counterpart of the 4-input select multiplexer and is used wherever one producer (e.g. the bus front end) feeds four consumers.

## Interface
- WIDTH, 32, data width of every stream
- DEPTH, 2, entries per output FIFO; power of two, ≥ 2
- clock  input  1  single clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  input word present
- in_ready  output  1  input word accepted this cycle when in_valid & in_ready
- in_data  input  WIDTH  input word
- in_sel  input  2  destination port 0..3
- out_valid  output  4  bit k: port k FIFO non-empty
- out_ready  input  4  bit k: consumer k takes head this cycle
- out_data0..out_data3  output  WIDTH each  head entry of port k FIFO
- busy  output  1  any FIFO non-empty

## Operation
- Push: in_valid & in_ready writes in_data into FIFO[in_sel] tail.
- in_ready = !full[in_sel]; combinational from in_sel and registered state only, never from out_ready (no ready pass-through). A full FIFO refuses a push even if it is popped in the same cycle.
- Pop: out_valid[k] & out_ready[k] removes FIFO[k] head; out_ready[k] while out_valid[k]=0 is ignored.
- Ports operate independently; up to four pops plus one push per cycle.
- Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged, both pointers advance.
- Simultaneous push and pop on an empty FIFO: pop ignored (out_valid was 0), push lands, count becomes 1.
- Strict in-order delivery per port. No reordering across the input: a blocked in_sel stalls the whole input stream (head-of-line blocking by design).
- Pointers wrap modulo DEPTH; count width $clog2(DEPTH+1), range 0..DEPTH, never over/underflows.
- out_dataK shows storage[rd_ptr] at all times; value undefined-but-stable is not allowed: it shows the last written content, 0 after reset.
- in_sel and in_data are don't-care when in_valid=0.

## Timing
- Reset (async assert, sync deassert assumed from the system): all counts and pointers 0, out_valid=4'b0000, out_data0..3=0, busy=0, in_ready=1. Storage cleared to 0.
- Reset asserted mid-transfer: all buffered words discarded immediately; no output handshake completes in that cycle.
- Latency: word accepted on edge n is visible on out_valid/out_dataK after edge n, i.e. available for pop in cycle n+1. No combinational in→out path.
- Throughput: one word/cycle sustained into any port whose consumer holds out_ready=1.
- busy is registered-state derived (OR of non-empty), no combinational input dependency.

## Structure
- Shared package: none needed beyond the existing constants; WIDTH/DEPTH are module parameters.
- One sub-module: demux_fifo (WIDTH, DEPTH; clock, reset_n, push, push_data, pop, full, empty, head). demultiplexer4 instantiates four, decodes in_sel to push strobes, and ORs empties into busy. Top ~120 lines, FIFO ~100.

## Test plan
- Reset: reset_n=0 with in_valid=1, in_sel=2 -> out_valid=0000, busy=0, in_ready=1, out_data2=0; release, no word appears.
- Routing: push 0xA0,0xA1,0xA2,0xA3 with in_sel=0,1,2,3, out_ready=1111 -> each out_validK high one cycle after its push with out_dataK=0xA0+K.
- Full/backpressure (DEPTH=2): out_ready=0000, push 0x11,0x22,0x33 to sel=1 -> third push sees in_ready=0; raise out_ready[1] -> pops 0x11 then 0x22, then 0x33 accepted and delivered, order preserved.
- Full + simultaneous pop: port 3 full, out_ready[3]=1 and push to sel=3 same cycle -> push refused (in_ready=0), accepted next cycle.
- Isolation/head-of-line: port 0 full and stalled; push to sel=2 succeeds; push to sel=0 stalls input while port 2 keeps draining.
- Wrap and mid-run reset: 10 words through port 1 with random out_ready -> exact order; assert reset_n with 2 words buffered -> out_valid[1]=0 immediately, busy=0.
